servo_slew_mux: RTL and testbench

SERVO_SLEW_MUX -- requirements
Module: servo_slew_mux

---
 rtl/servo_pkg.sv | 21 ++
 rtl/servo_slew_channel.sv | 103 ++++++++++
 rtl/servo_slew_mux.sv | 84 ++++++++
 tb/tb_servo_slew_mux.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared constants and types for the servo slew multiplexer.
// Holds angle width defaults, the signed working width and channel states.
package servo_pkg;

  localparam int ANGLE_W_DEF   = 16;
  localparam int ANGLE_MAX_DEF = 90;

  // Two extra bits let +/-(2^W-1) and target-current
  // differences stay representable without overflow.
  function automatic int sang_w(input int aw);
    return aw + 2;
  endfunction

  localparam int SANG_W = sang_w(ANGLE_W_DEF);

  typedef enum logic {
    SETTLED = 1'b0,
    SLEWING = 1'b1
  } ch_state_e;

endpackage

// File: rtl/servo_slew_channel.sv
// One servo channel: target forming, clamp, rate-limited slew, settled flag.
// Ports: clk, rst_a_n, tick, home, in_abs/in_neg -> out_abs, out_neg, settled.
module servo_slew_channel
  import servo_pkg::*;
#(
  parameter int   ANGLE_W   = ANGLE_W_DEF,
  parameter int   ANGLE_MAX = ANGLE_MAX_DEF,
  parameter int   STEP      = 1,
  parameter logic INV       = 1'b0
) (
  input  logic               clk,
  input  logic               rst_a_n,
  input  logic               tick,
  input  logic               home,
  input  logic [ANGLE_W-1:0] in_abs,
  input  logic               in_neg,
  output logic [ANGLE_W-1:0] out_abs,
  output logic               out_neg,
  output logic               settled
);

  localparam int SW = sang_w(ANGLE_W);
  typedef logic signed [SW-1:0] sang_t;

  localparam sang_t LIM = sang_t'(ANGLE_MAX);
  localparam sang_t STP = sang_t'(STEP);

  sang_t     w_mag;
  sang_t     w_raw;
  sang_t     w_tgt;
  sang_t     w_diff;
  sang_t     w_cur_nxt;
  sang_t     r_cur;
  ch_state_e r_state;
  ch_state_e w_state_nxt;

  logic [ANGLE_W-1:0] r_out_abs;
  logic               r_out_neg;
  logic               r_settled;

  assign w_mag = $signed({2'b00, in_abs});
  assign w_raw = (in_neg ^ INV) ? -w_mag : w_mag;

  always_comb begin
    w_tgt = w_raw;
    if (home)
      w_tgt = '0;
    else if (w_raw > LIM)
      w_tgt = LIM;
    else if (w_raw < -LIM)
      w_tgt = -LIM;
  end

  assign w_diff = w_tgt - r_cur;

  always_comb begin
    w_cur_nxt = r_cur;
    if (tick) begin
      if (w_diff > STP)
        w_cur_nxt = r_cur + STP;
      else if (w_diff < -STP)
        w_cur_nxt = r_cur - STP;
      else
        w_cur_nxt = w_tgt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      SETTLED:
        if (w_tgt != r_cur)
          w_state_nxt = SLEWING;
      SLEWING:
        if (w_cur_nxt == w_tgt)
          w_state_nxt = SETTLED;
      default:
        w_state_nxt = SLEWING;
    endcase
  end

  always_ff @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) begin
      r_cur     <= '0;
      r_state   <= SETTLED;
      r_settled <= 1'b1;
      r_out_abs <= '0;
      r_out_neg <= 1'b0;
    end else begin
      r_cur     <= w_cur_nxt;
      r_state   <= w_state_nxt;
      r_settled <= (w_state_nxt == SETTLED);
      // Sign-magnitude view of current; zero is never negative.
      r_out_abs <= ANGLE_W'(r_cur[SW-1] ? -r_cur : r_cur);
      r_out_neg <= r_cur[SW-1];
    end
  end

  assign out_abs = r_out_abs;
  assign out_neg = r_out_neg;
  assign settled = r_settled;

endmodule

// File: rtl/servo_slew_mux.sv
// Two-source servo target mux with shared slew tick and mode synchronizer.
// Ports: clk, rst_a_n, mode_sel, home, freeze, src0/src1 -> out, settled, tick.
module servo_slew_mux
  import servo_pkg::*;
#(
  parameter int                NUM_CH      = 3,
  parameter int                ANGLE_W     = ANGLE_W_DEF,
  parameter int                ANGLE_MAX   = ANGLE_MAX_DEF,
  parameter int                STEP        = 1,
  parameter int                TICK_DIV    = 500_000,
  parameter logic [NUM_CH-1:0] INVERT_MASK = '0
) (
  input  logic                      clk,
  input  logic                      rst_a_n,
  input  logic                      mode_sel,
  input  logic                      home,
  input  logic                      freeze,
  input  logic [NUM_CH*ANGLE_W-1:0] src0_abs,
  input  logic [NUM_CH-1:0]         src0_neg,
  input  logic [NUM_CH*ANGLE_W-1:0] src1_abs,
  input  logic [NUM_CH-1:0]         src1_neg,
  output logic [NUM_CH*ANGLE_W-1:0] out_abs,
  output logic [NUM_CH-1:0]         out_neg,
  output logic [NUM_CH-1:0]         settled,
  output logic                      tick
);

  localparam int CNT_W =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(TICK_DIV - 1);

  logic             r_sync0;
  logic             r_sync1;
  logic [CNT_W-1:0] r_cnt;
  logic             w_tick;

  logic [NUM_CH*ANGLE_W-1:0] w_sel_abs;
  logic [NUM_CH-1:0]         w_sel_neg;

  always_ff @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) begin
      r_sync0 <= 1'b0;
      r_sync1 <= 1'b0;
    end else begin
      r_sync0 <= mode_sel;
      r_sync1 <= r_sync0;
    end
  end

  always_ff @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n)
      r_cnt <= '0;
    else if (!freeze)
      r_cnt <= (r_cnt == CNT_MAX) ? '0 : r_cnt + 1'b1;
  end

  // Gated by reset so tick reads 0 even when TICK_DIV is 1.
  assign w_tick = rst_a_n && !freeze && (r_cnt == CNT_MAX);
  assign tick   = w_tick;

  assign w_sel_abs = r_sync1 ? src1_abs : src0_abs;
  assign w_sel_neg = r_sync1 ? src1_neg : src0_neg;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    servo_slew_channel #(
      .ANGLE_W   (ANGLE_W),
      .ANGLE_MAX (ANGLE_MAX),
      .STEP      (STEP),
      .INV       (INVERT_MASK[i])
    ) u_ch (
      .clk     (clk),
      .rst_a_n (rst_a_n),
      .tick    (w_tick),
      .home    (home),
      .in_abs  (w_sel_abs[i*ANGLE_W +: ANGLE_W]),
      .in_neg  (w_sel_neg[i]),
      .out_abs (out_abs[i*ANGLE_W +: ANGLE_W]),
      .out_neg (out_neg[i]),
      .settled (settled[i])
    );
  end

endmodule

// File: tb/tb_servo_slew_mux.sv
// Directed bench for servo_slew_mux: vector table plus hand sequences.
// Covers reset, ramps, clamp, invert, mode switch, freeze and mid-ramp reset.
module tb_servo_slew_mux;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst_a_n;
  logic          mode_sel;
  logic          home;
  logic          freeze;
  logic [3*W-1:0] src0_abs;
  logic [2:0]    src0_neg;
  logic [3*W-1:0] src1_abs;
  logic [2:0]    src1_neg;
  logic [3*W-1:0] out_abs;
  logic [2:0]    out_neg;
  logic [2:0]    settled;
  logic          tick;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  servo_slew_mux #(
    .NUM_CH      (3),
    .ANGLE_W     (W),
    .ANGLE_MAX   (90),
    .STEP        (5),
    .TICK_DIV    (4),
    .INVERT_MASK (3'b100)
  ) dut (
    .clk      (clk),
    .rst_a_n  (rst_a_n),
    .mode_sel (mode_sel),
    .home     (home),
    .freeze   (freeze),
    .src0_abs (src0_abs),
    .src0_neg (src0_neg),
    .src1_abs (src1_abs),
    .src1_neg (src1_neg),
    .out_abs  (out_abs),
    .out_neg  (out_neg),
    .settled  (settled),
    .tick     (tick)
  );

  typedef struct {
    logic [3*W-1:0] abs;
    logic [2:0]     neg;
    logic           hm;
    int             ticks;
    logic [3*W-1:0] eabs;
    logic [2:0]     eneg;
    logic [2:0]     eset;
  } vec_t;

  vec_t vt[13];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Wait for a tick, then for the output register to follow.
  task automatic step();
    int n = 0;
    while (tick !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      total++;
      bad++;
      $display("FAIL tick_timeout got=none want=tick");
    end
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [3*W-1:0] pk(input int a2,
                                        input int a1,
                                        input int a0);
    return {W'(a2), W'(a1), W'(a0)};
  endfunction

  initial begin
    vt[0]  = '{pk(0,0,20),     3'b000, 0, 1,  pk(0,0,5),    3'b000, 3'b110};
    vt[1]  = '{pk(0,0,20),     3'b000, 0, 1,  pk(0,0,10),   3'b000, 3'b110};
    vt[2]  = '{pk(0,0,20),     3'b000, 0, 1,  pk(0,0,15),   3'b000, 3'b110};
    vt[3]  = '{pk(0,0,20),     3'b000, 0, 1,  pk(0,0,20),   3'b000, 3'b111};
    vt[4]  = '{pk(0,0,20),     3'b000, 1, 4,  pk(0,0,0),    3'b000, 3'b111};
    vt[5]  = '{pk(0,0,7),      3'b000, 0, 1,  pk(0,0,5),    3'b000, 3'b110};
    vt[6]  = '{pk(0,0,7),      3'b000, 0, 1,  pk(0,0,7),    3'b000, 3'b111};
    vt[7]  = '{pk(0,120,7),    3'b010, 0, 17, pk(0,85,7),   3'b010, 3'b101};
    vt[8]  = '{pk(0,120,7),    3'b010, 0, 1,  pk(0,90,7),   3'b010, 3'b111};
    vt[9]  = '{pk(30,120,7),   3'b110, 0, 5,  pk(25,90,7),  3'b010, 3'b011};
    vt[10] = '{pk(30,120,7),   3'b110, 0, 1,  pk(30,90,7),  3'b010, 3'b111};
    vt[11] = '{pk(30,65535,7), 3'b100, 0, 18, pk(30,0,7),   3'b000, 3'b101};
    vt[12] = '{pk(30,65535,7), 3'b100, 0, 18, pk(30,90,7),  3'b000, 3'b111};

    rst_a_n  = 1'b0;
    mode_sel = 1'b0;
    home     = 1'b0;
    freeze   = 1'b0;
    src0_abs = '0;
    src0_neg = '0;
    src1_abs = '0;
    src1_neg = '0;

    repeat (3) @(negedge clk);
    chk("rst_abs", 64'(out_abs), 64'd0);
    chk("rst_neg", 64'(out_neg), 64'd0);
    chk("rst_set", 64'(settled), 64'b111);
    chk("rst_tick", 64'(tick), 64'd0);
    rst_a_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 13; v++) begin
      src0_abs = vt[v].abs;
      src0_neg = vt[v].neg;
      home     = vt[v].hm;
      for (int t = 0; t < vt[v].ticks; t++)
        step();
      chk($sformatf("v%0d_abs", v), 64'(out_abs), 64'(vt[v].eabs));
      chk($sformatf("v%0d_neg", v), 64'(out_neg), 64'(vt[v].eneg));
      chk($sformatf("v%0d_set", v), 64'(settled), 64'(vt[v].eset));
    end

    // Bring ch0 to +15, then switch to source 1 (ch0 = -10).
    src0_abs = pk(30, 65535, 15);
    step();
    step();
    chk("pre_sw_abs", 64'(out_abs), 64'(pk(30, 90, 15)));
    src1_abs = pk(30, 90, 10);
    src1_neg = 3'b101;
    mode_sel = 1'b1;
    @(negedge clk);
    chk("sw_c1_set", 64'(settled), 64'b111);
    @(negedge clk);
    chk("sw_c2_set", 64'(settled), 64'b111);
    @(negedge clk);
    chk("sw_c3_set", 64'(settled), 64'b110);
    chk("sw_nojump", 64'(out_abs[W-1:0]), 64'd15);
    @(posedge clk);
    @(negedge clk);
    chk("sw_10", 64'({out_neg[0], out_abs[W-1:0]}), 64'({1'b0, W'(10)}));
    step();
    chk("sw_5", 64'({out_neg[0], out_abs[W-1:0]}), 64'({1'b0, W'(5)}));
    step();
    chk("sw_0", 64'({out_neg[0], out_abs[W-1:0]}), 64'({1'b0, W'(0)}));
    step();
    chk("sw_m5", 64'({out_neg[0], out_abs[W-1:0]}), 64'({1'b1, W'(5)}));
    step();
    chk("sw_m10", 64'({out_neg[0], out_abs[W-1:0]}), 64'({1'b1, W'(10)}));
    chk("sw_set", 64'(settled), 64'b111);

    // Freeze mid-ramp toward +40.
    src1_abs = pk(30, 90, 40);
    src1_neg = 3'b100;
    step();
    chk("fz_pre", 64'({out_neg[0], out_abs[W-1:0]}), 64'({1'b1, W'(5)}));
    freeze = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("fz_tick%0d", c), 64'(tick), 64'd0);
      chk($sformatf("fz_hold%0d", c),
          64'({out_neg[0], out_abs[W-1:0]}), 64'({1'b1, W'(5)}));
    end
    freeze = 1'b0;
    @(negedge clk);
    chk("fz_res1", 64'(tick), 64'd0);
    @(negedge clk);
    chk("fz_res2", 64'(tick), 64'd1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("fz_0", 64'({out_neg[0], out_abs[W-1:0]}), 64'({1'b0, W'(0)}));
    step();
    chk("fz_5", 64'({out_neg[0], out_abs[W-1:0]}), 64'({1'b0, W'(5)}));

    // Reset mid-ramp, then restart from zero.
    #2;
    rst_a_n = 1'b0;
    #1;
    chk("mr_abs", 64'(out_abs), 64'd0);
    chk("mr_neg", 64'(out_neg), 64'd0);
    chk("mr_set", 64'(settled), 64'b111);
    chk("mr_tick", 64'(tick), 64'd0);
    @(negedge clk);
    mode_sel = 1'b1;
    rst_a_n  = 1'b1;
    repeat (3) @(negedge clk);
    step();
    chk("rr_abs", 64'(out_abs), 64'(pk(5, 5, 5)));
    chk("rr_neg", 64'(out_neg), 64'd0);
    chk("rr_set", 64'(settled), 64'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
